// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register plus data-memory formatter: drives word address,
// byte enables and replicated store data, extends load data, flags misalignment.
module ex_mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_alu_res,
  input  logic [31:0] ex_rt_data,
  input  logic [3:0]  ex_mem_op,
  input  logic [4:0]  ex_rd_addr,
  input  logic        ex_reg_write,
  input  logic [31:0] dm_rdata,
  output logic [31:0] m_pc,
  output logic [31:0] m_alu_res,
  output logic [4:0]  m_rd_addr,
  output logic        m_reg_write,
  output logic [31:0] dm_addr,
  output logic        dm_we,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  output logic [31:0] m_load_data,
  output logic        m_is_load,
  output logic        m_misalign
);

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_LW   = 4'd1;
  localparam logic [3:0] OP_LH   = 4'd2;
  localparam logic [3:0] OP_LHU  = 4'd3;
  localparam logic [3:0] OP_LB   = 4'd4;
  localparam logic [3:0] OP_LBU  = 4'd5;
  localparam logic [3:0] OP_SW   = 4'd6;
  localparam logic [3:0] OP_SH   = 4'd7;
  localparam logic [3:0] OP_SB   = 4'd8;

  logic [31:0] pc_reg;
  logic [31:0] alu_res_reg;
  logic [31:0] rt_data_reg;
  logic [3:0]  mem_op_reg;
  logic [4:0]  rd_addr_reg;
  logic        reg_write_reg;

  logic [3:0]  mem_op_next;
  logic        is_load;
  logic        is_store;
  logic        misalign;
  logic [3:0]  be_raw;
  logic [31:0] wdata_raw;
  logic [31:0] byte_rep;
  logic [31:0] half_rep;
  logic [15:0] half_sel;
  logic [7:0]  byte_sel;
  logic [31:0] load_raw;

  // Undefined opcodes are squashed here so the decode below only sees 0-8.
  assign mem_op_next = (ex_mem_op > OP_SB) ? OP_NONE : ex_mem_op;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      pc_reg        <= '0;
      alu_res_reg   <= '0;
      rt_data_reg   <= '0;
      mem_op_reg    <= OP_NONE;
      rd_addr_reg   <= '0;
      reg_write_reg <= 1'b0;
    end else if (!stall) begin
      pc_reg        <= ex_pc;
      alu_res_reg   <= ex_alu_res;
      rt_data_reg   <= ex_rt_data;
      mem_op_reg    <= mem_op_next;
      rd_addr_reg   <= ex_rd_addr;
      reg_write_reg <= ex_reg_write;
    end
  end

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    misalign = 1'b0;
    case (mem_op_reg)
      OP_LW:         begin is_load  = 1'b1; misalign = |alu_res_reg[1:0]; end
      OP_LH, OP_LHU: begin is_load  = 1'b1; misalign = alu_res_reg[0];    end
      OP_LB, OP_LBU: begin is_load  = 1'b1;                               end
      OP_SW:         begin is_store = 1'b1; misalign = |alu_res_reg[1:0]; end
      OP_SH:         begin is_store = 1'b1; misalign = alu_res_reg[0];    end
      OP_SB:         begin is_store = 1'b1;                               end
      default:       ;
    endcase
  end

  // Replicate the store operand across lanes; byte enables pick the live one.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte_lane
      assign byte_rep[8*gi +: 8] = rt_data_reg[7:0];
    end
    for (genvar gi = 0; gi < 2; gi++) begin : g_half_lane
      assign half_rep[16*gi +: 16] = rt_data_reg[15:0];
    end
  endgenerate

  always_comb begin
    be_raw    = 4'b0000;
    wdata_raw = '0;
    case (mem_op_reg)
      OP_SW: begin
        be_raw    = 4'b1111;
        wdata_raw = rt_data_reg;
      end
      OP_SH: begin
        be_raw    = alu_res_reg[1] ? 4'b1100 : 4'b0011;
        wdata_raw = half_rep;
      end
      OP_SB: begin
        be_raw    = 4'b0001 << alu_res_reg[1:0];
        wdata_raw = byte_rep;
      end
      default: ;
    endcase
  end

  always_comb begin
    half_sel = alu_res_reg[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    case (alu_res_reg[1:0])
      2'd0:    byte_sel = dm_rdata[7:0];
      2'd1:    byte_sel = dm_rdata[15:8];
      2'd2:    byte_sel = dm_rdata[23:16];
      default: byte_sel = dm_rdata[31:24];
    endcase
    case (mem_op_reg)
      OP_LW:   load_raw = dm_rdata;
      OP_LH:   load_raw = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_raw = {16'h0000, half_sel};
      OP_LB:   load_raw = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_raw = {24'h000000, byte_sel};
      default: load_raw = '0;
    endcase
  end

  assign m_pc        = pc_reg;
  assign m_alu_res   = alu_res_reg;
  assign m_rd_addr   = rd_addr_reg;
  assign m_is_load   = is_load;
  assign m_misalign  = misalign;
  assign m_reg_write = reg_write_reg & ~(is_load & misalign);
  assign dm_addr     = {alu_res_reg[31:2], 2'b00};
  // A stalled store is held off so it commits exactly once, on release.
  assign dm_we       = is_store & ~misalign & ~stall;
  assign dm_be       = misalign ? 4'b0000 : be_raw;
  assign dm_wdata    = wdata_raw;
  assign m_load_data = misalign ? 32'h0 : load_raw;

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Pipeline register and memory-access formatter between the EX stage and the data memory of the pipelined MIPS core. It latches EX results at each clock edge and drives the word-addressed data memory with a word address, byte enables and lane-replicated store data. It also sign- or zero-extends the word returned by the memory for the MEM/WB stage, and flags misaligned accesses. Stall and flush inputs give the hazard unit control over the stage.

## Interface
- No parameters.
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  reset, synchronous, active-high
- stall  in  1  hold the current stage contents
- flush  in  1  load a bubble (all-zero fields)
- ex_pc  in  32  PC of the instruction in EX
- ex_alu_res  in  32  effective address, or ALU result for non-memory ops
- ex_rt_data  in  32  store source register value
- ex_mem_op  in  4  0 none, 1 lw, 2 lh, 3 lhu, 4 lb, 5 lbu, 6 sw, 7 sh, 8 sb; 9-15 treated as 0
- ex_rd_addr  in  5  destination register
- ex_reg_write  in  1  instruction writes the register file
- dm_rdata  in  32  word read from data memory (asynchronous read)
- m_pc  out  32  latched PC, forwarded to memory for write trace
- m_alu_res  out  32  latched ALU result
- m_rd_addr  out  5  latched destination
- m_reg_write  out  1  latched write enable, forced 0 on misaligned load
- dm_addr  out  32  {m_alu_res[31:2], 2'b00}
- dm_we  out  1  store strobe
- dm_be  out  4  byte enables; bit i covers dm_wdata[8i+7:8i]
- dm_wdata  out  32  lane-replicated store data
- m_load_data  out  32  extended load result; 0 when not a valid load
- m_is_load  out  1  latched op is lw/lh/lhu/lb/lbu
- m_misalign  out  1  latched access violates natural alignment

## Operation
- Registered fields: pc, alu_res, rt_data, mem_op (normalised, 9-15 become 0), rd_addr, reg_write.
- Update priority per edge: reset > flush > stall > capture. Reset and flush both load all-zero fields. Stall keeps the fields unchanged.
- Alignment rules:
  - lw and sw require addr[1:0] == 0.
  - lh, lhu and sh require addr[0] == 0.
  - Byte ops are always aligned.
- m_misalign is 1 when the latched op is a memory op and its alignment rule fails.
- Store formatting (combinational from latched fields):
  - sw: be = 4'b1111, wdata = rt.
  - sh: be = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{rt[15:0]}}.
  - sb: be = 4'b0001 << addr[1:0], wdata = {4{rt[7:0]}}.
  - Non-store ops: be = 0, wdata = 0.
- dm_we = is_store & ~m_misalign & ~stall. A held store writes exactly once, in the cycle stall deasserts.
- A misaligned store gives dm_we = 0 and dm_be = 0. Memory is unchanged.
- Load extraction from dm_rdata:
  - lw returns the word.
  - lh/lhu select the half dm_rdata[16*addr[1]+15 -: 16], then sign-extend (lh) or zero-extend (lhu).
  - lb/lbu select the byte dm_rdata[8*addr[1:0]+7 -: 8], then sign-extend (lb) or zero-extend (lbu).
- A misaligned load gives m_load_data = 0 and m_reg_write = 0. m_misalign stays high for the exception logic.

## Timing
- Single-cycle stage latency: EX inputs present before edge N appear on m_* from edge N through edge N+1.
- dm_addr, dm_be, dm_wdata, dm_we and m_load_data are combinational from the stage register. m_load_data also depends combinationally on dm_rdata, and is valid in the same cycle because the memory read is asynchronous.
- The memory samples dm_we/dm_wdata at edge N+1. Load data is consumed by MEM/WB at edge N+1.
- Reset values for one cycle after a reset edge:
  - All m_* outputs are 0, and dm_addr, dm_wdata and m_load_data are 0.
  - dm_we = 0, dm_be = 0, m_is_load = 0, m_misalign = 0.
- Reset asserted mid-stall or together with flush still zeroes the stage at that edge.
- stall and flush asserted together: flush wins.
- A bubble drives no memory access and no register write.

## Test plan
- Reset then sw, alu_res=0x0000_0008, rt=0xDEAD_BEEF -> next cycle dm_addr=0x8, dm_be=4'b1111, dm_wdata=0xDEADBEEF, dm_we=1. After reset, all outputs are 0.
- sb at 0x13, rt=0x0000_00A5 -> dm_addr=0x10, dm_be=4'b1000, dm_wdata=0xA5A5A5A5. sh at 0x12, rt=0x1234 -> dm_be=4'b1100, dm_wdata=0x12341234.
- dm_rdata=0x80FF_7F01:
  - lb at 0x3 -> 0xFFFFFF80.
  - lbu at 0x3 -> 0x00000080.
  - lh at 0x2 -> 0xFFFF80FF.
  - lhu at 0x0 -> 0x00007F01.
  - lw -> 0x80FF7F01.
- Misaligned: sw at 0x6 -> dm_we=0, dm_be=0, m_misalign=1. lh at 0x5 -> m_load_data=0, m_reg_write=0, m_misalign=1.
- sw latched, stall held for 3 cycles -> dm_we=0 while stalled and fields are unchanged. dm_we=1 for exactly one cycle after release.
- stall and flush together while a store is latched -> next cycle is a bubble with all fields 0 and dm_we=0. A reset asserted during a stall zeroes the stage at that edge.
